// File: rtl/dbg_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dbg_loader
// Function : UART framed program loader and debug memory port arbiter; owns
//            the CPU reset line.
// Revision : 1.0
// ============================================================================
module dbg_loader #(
    parameter bit BOOT_HOLD   = 1'b1,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        mem_ready,
    output logic        cpu_n_reset,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do
);

    localparam logic [7:0] C_SYNC     = 8'hA5;
    localparam logic [7:0] C_CMD_LOAD = 8'h01;
    localparam logic [7:0] C_CMD_RUN  = 8'h02;
    localparam logic [7:0] C_CMD_HALT = 8'h03;
    localparam logic [7:0] C_RSP_OK   = 8'h4F;
    localparam logic [7:0] C_RSP_ERR  = 8'h45;

    localparam int                   C_TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [C_TMO_W-1:0]   C_TMO_LAST = C_TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_CNT   = 3'd3,
        S_DATA  = 3'd4,
        S_WRITE = 3'd5,
        S_SUM   = 3'd6,
        S_RESP  = 3'd7
    } state_t;

    state_t               r_state;
    logic [1:0]           r_idx;
    logic [15:0]          r_cnt;
    logic [7:0]           r_sum;
    logic [C_TMO_W-1:0]   r_tmo;
    logic                 r_cpu_n_reset;
    logic                 r_tx_valid;
    logic [7:0]           r_tx_data;
    logic                 r_mem_op;
    logic [3:0]           r_wren;
    logic [31:0]          r_adr;
    logic [31:0]          r_do;

    logic                 w_rx_ready;
    logic                 w_rx_fire;
    logic                 w_tmo_armed;
    logic                 w_timeout;
    logic [15:0]          w_cnt_full;

    assign w_rx_ready  = (r_state != S_WRITE) && (r_state != S_RESP);
    assign w_rx_fire   = rx_valid && w_rx_ready;
    assign w_tmo_armed = (r_state != S_IDLE) && (r_state != S_RESP) && (r_state != S_WRITE);
    assign w_timeout   = w_tmo_armed && !w_rx_fire && (r_tmo == C_TMO_LAST);
    assign w_cnt_full  = {rx_data, r_cnt[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= 2'd0;
            r_cnt         <= 16'd0;
            r_sum         <= 8'd0;
            r_tmo         <= '0;
            r_cpu_n_reset <= !BOOT_HOLD;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= 8'd0;
            r_mem_op      <= 1'b0;
            r_wren        <= 4'd0;
            r_adr         <= 32'd0;
            r_do          <= 32'd0;
        end else begin
            r_tmo <= (w_rx_fire || !w_tmo_armed) ? '0 : r_tmo + C_TMO_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire && rx_data == C_SYNC)
                        r_state <= S_CMD;
                end
                S_CMD: begin
                    if (w_rx_fire) begin
                        case (rx_data)
                            C_CMD_LOAD: begin
                                r_cpu_n_reset <= 1'b0;
                                r_idx         <= 2'd0;
                                r_sum         <= 8'd0;
                                r_state       <= S_ADDR;
                            end
                            C_CMD_RUN: begin
                                r_cpu_n_reset <= 1'b1;
                                r_tx_valid    <= 1'b1;
                                r_tx_data     <= C_RSP_OK;
                                r_state       <= S_RESP;
                            end
                            C_CMD_HALT: begin
                                r_cpu_n_reset <= 1'b0;
                                r_tx_valid    <= 1'b1;
                                r_tx_data     <= C_RSP_OK;
                                r_state       <= S_RESP;
                            end
                            default: begin
                                r_tx_valid <= 1'b1;
                                r_tx_data  <= C_RSP_ERR;
                                r_state    <= S_RESP;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (w_rx_fire) begin
                        // Low address bits are dropped as the first byte arrives
                        r_adr[{r_idx, 3'b000} +: 8] <= (r_idx == 2'd0) ? {rx_data[7:2], 2'b00} : rx_data;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3)
                            r_state <= S_CNT;
                    end
                end
                S_CNT: begin
                    if (w_rx_fire) begin
                        if (r_idx == 2'd0) begin
                            r_cnt[7:0] <= rx_data;
                            r_idx      <= 2'd1;
                        end else begin
                            r_cnt   <= w_cnt_full;
                            r_idx   <= 2'd0;
                            r_state <= (w_cnt_full == 16'd0) ? S_SUM : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_do[{r_idx, 3'b000} +: 8] <= rx_data;
                        r_sum <= r_sum + rx_data;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_mem_op <= 1'b1;
                            r_wren   <= 4'hF;
                            r_state  <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        r_mem_op <= 1'b0;
                        r_wren   <= 4'd0;
                        r_adr    <= r_adr + 32'd4;
                        r_cnt    <= r_cnt - 16'd1;
                        r_state  <= (r_cnt == 16'd1) ? S_SUM : S_DATA;
                    end
                end
                S_SUM: begin
                    if (w_rx_fire) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= (rx_data == r_sum) ? C_RSP_OK : C_RSP_ERR;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // An idle link aborts the frame; completed writes are kept
            if (w_timeout) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= C_RSP_ERR;
                r_state    <= S_RESP;
            end
        end
    end

    assign rx_ready    = w_rx_ready;
    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign cpu_n_reset = r_cpu_n_reset;
    assign dbg_mem_op  = r_mem_op;
    assign dbg_wren    = r_wren;
    assign dbg_adr     = r_adr;
    assign dbg_do      = r_do;

endmodule
`default_nettype wire

// File: tb/tb_dbg_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dbg_loader
// Function : Directed bench for dbg_loader with write and response scoreboards.
// Revision : 1.0
// ============================================================================
module tb_dbg_loader;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        tx_ready = 1'b0;
    logic        mem_ready = 1'b0;
    logic        rx_ready, tx_valid, cpu_n_reset, dbg_mem_op;
    logic [7:0]  tx_data;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr, dbg_do;

    always #5 clk = ~clk;

    dbg_loader #(.BOOT_HOLD(1'b1), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .mem_ready(mem_ready), .cpu_n_reset(cpu_n_reset),
        .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr),
        .dbg_do(dbg_do)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    logic [63:0] wr_q[$];
    logic [7:0]  rsp_q[$];
    logic [31:0] img[7];
    int mem_delay = 2;
    bit mem_hold = 1'b0;
    int n_writes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            if (rx_ready) begin
                @(posedge clk);
                break;
            end
            @(negedge clk);
            w++;
            if (w > 500) begin
                check("rx_accept_timeout", 0, 1);
                break;
            end
        end
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] addr, input logic [15:0] cnt);
        send_byte(8'hA5);
        send_byte(8'h01);
        check("load_cpu_hold", cpu_n_reset, 0);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
    endtask

    task automatic load(input logic [31:0] addr, input logic [15:0] n,
                        input logic [7:0] sum_adj, input logic [7:0] rsp);
        logic [31:0] a;
        logic [7:0]  s;
        a = {addr[31:2], 2'b00};
        s = 8'd0;
        for (int i = 0; i < int'(n); i++) begin
            wr_q.push_back({a, img[i]});
            a = a + 32'd4;
        end
        rsp_q.push_back(rsp);
        send_hdr(addr, n);
        for (int i = 0; i < int'(n); i++)
            for (int j = 0; j < 4; j++) begin
                send_byte(img[i][8*j +: 8]);
                s = s + img[i][8*j +: 8];
            end
        send_byte(s + sum_adj);
    endtask

    task automatic get_resp(input int hold, input int lat);
        int w;
        bit st;
        logic [7:0] eb, d;
        w = 0;
        st = 1'b1;
        @(negedge clk);
        while (!tx_valid && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("resp_valid", tx_valid, 1);
        check("resp_latency", w, lat);
        eb = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'hxx;
        check("resp_byte", tx_data, eb);
        d = tx_data;
        repeat (hold) begin
            @(negedge clk);
            st &= tx_valid && (tx_data == d) && !rx_ready;
        end
        if (hold > 0) check("resp_stable", st, 1);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("resp_to_idle", {tx_valid, rx_ready}, 2'b01);
    endtask

    task automatic chk_reset_vals();
        check("rst_cpu_n_reset", cpu_n_reset, 0);
        check("rst_mem_op", dbg_mem_op, 0);
        check("rst_wren", dbg_wren, 0);
        check("rst_adr", dbg_adr, 0);
        check("rst_do", dbg_do, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rx_ready", rx_ready, 1);
    endtask

    // Memory model: checks each write against the scoreboard and acknowledges it
    initial begin
        logic [63:0] e;
        logic [31:0] a, d;
        bit st;
        int w;
        forever begin
            @(negedge clk);
            if (dbg_mem_op) begin
                e = (wr_q.size() > 0) ? wr_q.pop_front() : 64'hx;
                check("wr_wren", dbg_wren, 32'hF);
                check("wr_adr", dbg_adr, e[63:32]);
                check("wr_data", dbg_do, e[31:0]);
                a = dbg_adr;
                d = dbg_do;
                st = 1'b1;
                if (mem_hold) begin
                    w = 0;
                    while (dbg_mem_op && w < 1000) begin
                        @(negedge clk);
                        w++;
                    end
                end else begin
                    repeat (mem_delay) begin
                        @(negedge clk);
                        st &= dbg_mem_op && (dbg_wren == 4'hF) && (dbg_adr == a)
                              && (dbg_do == d) && !rx_ready;
                    end
                    check("wr_stable", st, 1);
                    mem_ready = 1'b1;
                    @(negedge clk);
                    mem_ready = 1'b0;
                    check("wr_release", {dbg_mem_op, dbg_wren}, 0);
                    n_writes++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        img[0] = 32'h00010137; img[1] = 32'hff010113; img[2] = 32'h00020537;
        img[3] = 32'h08850513; img[4] = 32'h00a12623; img[5] = 32'h00c12583;
        img[6] = 32'h0000006f;

        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;

        // Full image with correct checksum, then RUN
        n0 = n_writes;
        load(32'h0002_0000, 16'd7, 8'd0, 8'h4F);
        get_resp(0, 0);
        check("img_writes", n_writes - n0, 7);
        check("img_cpu_held", cpu_n_reset, 0);
        rsp_q.push_back(8'h4F);
        send_byte(8'hA5); send_byte(8'h02);
        get_resp(0, 0);
        check("run_cpu", cpu_n_reset, 1);

        // Bad checksum still writes every word
        n0 = n_writes;
        load(32'h0002_0000, 16'd7, 8'd1, 8'h45);
        get_resp(0, 0);
        check("badsum_writes", n_writes - n0, 7);
        check("badsum_cpu", cpu_n_reset, 0);

        // Unaligned address at the top of memory wraps to zero
        n0 = n_writes;
        load(32'hFFFF_FFFE, 16'd2, 8'd0, 8'h4F);
        get_resp(0, 0);
        check("wrap_writes", n_writes - n0, 2);

        // Garbage before sync, then unknown command
        rsp_q.push_back(8'h45);
        send_byte(8'h00); send_byte(8'h11); send_byte(8'hA5); send_byte(8'h7E);
        get_resp(0, 0);

        // Zero-length load
        n0 = n_writes;
        load(32'h0000_1000, 16'd0, 8'd0, 8'h4F);
        get_resp(0, 0);
        check("cnt0_writes", n_writes - n0, 0);

        // Slow memory and slow transmitter
        mem_delay = 20;
        n0 = n_writes;
        load(32'h0000_0040, 16'd1, 8'd0, 8'h4F);
        get_resp(50, 0);
        check("slow_writes", n_writes - n0, 1);
        mem_delay = 2;

        // RUN then HALT
        rsp_q.push_back(8'h4F);
        send_byte(8'hA5); send_byte(8'h02);
        get_resp(0, 0);
        rsp_q.push_back(8'h4F);
        send_byte(8'hA5); send_byte(8'h03);
        get_resp(0, 0);
        check("halt_cpu", cpu_n_reset, 0);

        // Stall after two data bytes
        rsp_q.push_back(8'h45);
        send_hdr(32'h0000_0080, 16'd1);
        send_byte(8'h11); send_byte(8'h22);
        get_resp(0, TMO);
        check("tmo_cpu", cpu_n_reset, 0);

        // Reset while a write is outstanding
        mem_hold = 1'b1;
        wr_q.push_back({32'h0000_0100, 32'h12345678});
        send_hdr(32'h0000_0100, 16'd1);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        @(negedge clk);
        check("inflight_mem_op", dbg_mem_op, 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        @(negedge clk);
        mem_hold = 1'b0;

        // Loader recovers after reset
        rsp_q.push_back(8'h4F);
        send_byte(8'hA5); send_byte(8'h02);
        get_resp(0, 0);
        check("recover_cpu", cpu_n_reset, 1);
        check("wr_q_empty", wr_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
